// File: rtl/regfile_pkg.sv
// Shared types for the register-file access controller.
// Widths of the 64x32 RF port, queue entry and arbiter state.
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 6;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wbq_entry_t;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      FLUSH_DONE
   } arb_state_t;

endpackage

// File: rtl/regfile_access_ctrl_wb_queue.sv
// wb_queue: circular writeback FIFO with wrapping pointers.
// Ports: push/pop, full/empty/one/head, two youngest-match lookups.
module wb_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  wbq_entry_t        push_entry,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic              one,
   output wbq_entry_t        head,
   input  logic [ADDR_W-1:0] look_a,
   input  logic [ADDR_W-1:0] look_b,
   output logic              hit_a,
   output logic              hit_b,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b
);

   localparam int PW = $clog2(DEPTH);

   // Extra MSB on each pointer tells full from empty.
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] count;

   wbq_entry_t mem [DEPTH];

   assign count = wr_ptr - rd_ptr;
   assign full  = int'(count) == DEPTH;
   assign empty = count == '0;
   assign one   = int'(count) == 1;
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[PW-1:0]] <= push_entry;
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx    = '0;
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      data_a = '0;
      data_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr[PW-1:0] + PW'(i);
         if (i < int'(count)) begin
            if (mem[idx].addr == look_a) begin
               hit_a  = 1'b1;
               data_a = mem[idx].data;
            end
            if (mem[idx].addr == look_b) begin
               hit_b  = 1'b1;
               data_b = mem[idx].data;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Merges operand reads and writebacks onto the single-port 64x32 RF.
// Ports: rd_req/rd_rsp (decode), wb (execute/mem), flush, rf_* port.
// Option RF_BYPASS_EN: forward queued data to hazarding reads.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int WBQ_DEPTH  = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic              rd_rsp_valid,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [ADDR_W-1:0] rf_rs,
   output logic [ADDR_W-1:0] rf_rt,
   output logic [DATA_W-1:0] rf_writein,
   input  logic [DATA_W-1:0] rf_rsout,
   input  logic [DATA_W-1:0] rf_rtout
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_t        state;
   logic [SW-1:0]     starve_cnt;
   logic              rsp_valid_q;

   logic              q_full;
   logic              q_empty;
   logic              q_one;
   wbq_entry_t        q_head;
   logic              hit_a;
   logic              hit_b;
   logic [DATA_W-1:0] q_data_a;
   logic [DATA_W-1:0] q_data_b;

   logic              run_rd;
   logic              read_ok;
   logic              starve_hit;
   logic              grant_w;
   logic              grant_r;
   logic              q_push;

   wb_queue #(
      .DEPTH(WBQ_DEPTH)
   ) u_wbq (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (q_push),
      .push_entry ('{addr: wb_addr, data: wb_data}),
      .pop        (grant_w),
      .full       (q_full),
      .empty      (q_empty),
      .one        (q_one),
      .head       (q_head),
      .look_a     (rd_addr_a),
      .look_b     (rd_addr_b),
      .hit_a      (hit_a),
      .hit_b      (hit_b),
      .data_a     (q_data_a),
      .data_b     (q_data_b)
   );

   // A raised flush_req already blocks new traffic in RUN.
   assign run_rd = (state == RUN) && !flush_req;

`ifdef RF_BYPASS_EN
   assign read_ok = run_rd && rd_req_valid;
`else
   assign read_ok = run_rd && rd_req_valid && !(hit_a || hit_b);
`endif

   assign starve_hit = starve_cnt == SW'(STARVE_MAX);
   // Outside RUN read_ok is 0, so this also drains in FLUSH.
   assign grant_w = !q_empty && (q_full || starve_hit || !read_ok);
   assign grant_r = read_ok && !grant_w;
   assign q_push  = wb_valid && wb_ready;

   assign wb_ready     = !q_full && run_rd;
   assign rd_req_ready = grant_r;

   assign rf_write   = grant_w;
   assign rf_rt      = grant_w ? q_head.addr : '0;
   assign rf_writein = grant_w ? q_head.data : '0;
   assign rf_rd      = grant_r ? rd_addr_a : '0;
   assign rf_rs      = grant_r ? rd_addr_b : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RUN;
         starve_cnt  <= '0;
         rsp_valid_q <= 1'b0;
         flush_done  <= 1'b0;
      end else begin
         rsp_valid_q <= grant_r;
         flush_done  <= 1'b0;
         if (grant_w)
            starve_cnt <= '0;
         else if (grant_r && !q_empty && !starve_hit)
            starve_cnt <= starve_cnt + 1'b1;
         unique case (state)
            RUN: begin
               if (flush_req) state <= FLUSH;
            end
            FLUSH: begin
               if (q_empty || (q_one && grant_w)) begin
                  state      <= FLUSH_DONE;
                  flush_done <= 1'b1;
               end
            end
            FLUSH_DONE: begin
               if (!flush_req) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign rd_rsp_valid = rsp_valid_q;

`ifdef RF_BYPASS_EN
   logic              byp_a_q;
   logic              byp_b_q;
   logic [DATA_W-1:0] byp_da_q;
   logic [DATA_W-1:0] byp_db_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         byp_a_q  <= 1'b0;
         byp_b_q  <= 1'b0;
         byp_da_q <= '0;
         byp_db_q <= '0;
      end else if (grant_r) begin
         byp_a_q  <= hit_a;
         byp_b_q  <= hit_b;
         byp_da_q <= q_data_a;
         byp_db_q <= q_data_b;
      end
   end

   assign rd_data_a = !rsp_valid_q ? '0 :
                      byp_a_q ? byp_da_q : rf_rsout;
   assign rd_data_b = !rsp_valid_q ? '0 :
                      byp_b_q ? byp_db_q : rf_rtout;
`else
   logic unused_byp;
   assign unused_byp = ^{q_data_a, q_data_b};

   assign rd_data_a = rsp_valid_q ? rf_rsout : '0;
   assign rd_data_b = rsp_valid_q ? rf_rtout : '0;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: RF model plus pending-write model.
// Scenario tasks check directed cases, then a random run.
module tb_regfile_access_ctrl;
   import regfile_pkg::*;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              rd_rsp_valid;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              flush_req;
   logic              flush_done;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_rd;
   logic [ADDR_W-1:0] rf_rs;
   logic [ADDR_W-1:0] rf_rt;
   logic [DATA_W-1:0] rf_writein;
   logic [DATA_W-1:0] rf_rsout;
   logic [DATA_W-1:0] rf_rtout;

   always #5 clock = ~clock;

   regfile_access_ctrl dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_addr_a    (rd_addr_a),
      .rd_addr_b    (rd_addr_b),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_data_a    (rd_data_a),
      .rd_data_b    (rd_data_b),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .flush_req    (flush_req),
      .flush_done   (flush_done),
      .rf_write     (rf_write),
      .rf_rd        (rf_rd),
      .rf_rs        (rf_rs),
      .rf_rt        (rf_rt),
      .rf_writein   (rf_writein),
      .rf_rsout     (rf_rsout),
      .rf_rtout     (rf_rtout)
   );

   // Single-port register file behaviour.
   logic [DATA_W-1:0] rfm [64];
   always @(posedge clock) begin
      if (rf_write) rfm[rf_rt] <= rf_writein;
      else begin
         rf_rsout <= rfm[rf_rd];
         rf_rtout <= rfm[rf_rs];
      end
   end

   // Reference: architectural values, committed values, pending writes.
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;
   wr_t pq[$];
   logic [DATA_W-1:0] arch [64];
   logic [DATA_W-1:0] comm [64];

   int errors = 0;
   int checks = 0;
   int star = 0;

   int                pre_sz;
   logic              o_rd_ready, o_wb_ready, o_rf_write;
   logic [ADDR_W-1:0] o_rf_rt;
   logic [DATA_W-1:0] o_rf_wd;
   logic              has_front, hz, rd_acc, wb_acc;
   logic [ADDR_W-1:0] exp_rt;
   logic [DATA_W-1:0] exp_wd, exp_a, exp_b;
   logic              rsp_v, fdone;
   logic [DATA_W-1:0] rsp_a, rsp_b;

   // One clock: sample request side, advance model, sample response.
   task automatic tick();
      #1;
      pre_sz     = pq.size();
      o_rd_ready = rd_req_ready;
      o_wb_ready = wb_ready;
      o_rf_write = rf_write;
      o_rf_rt    = rf_rt;
      o_rf_wd    = rf_writein;
      has_front  = pq.size() > 0;
      exp_rt     = '0;
      exp_wd     = '0;
      if (has_front) begin
         exp_rt = pq[0].a;
         exp_wd = pq[0].d;
      end
      hz = 1'b0;
      foreach (pq[i])
         if (pq[i].a == rd_addr_a || pq[i].a == rd_addr_b) hz = 1'b1;
      rd_acc = rd_req_valid && rd_req_ready;
      wb_acc = wb_valid && wb_ready;
      if (o_rf_write && has_front) begin
         comm[pq[0].a] = pq[0].d;
         void'(pq.pop_front());
         star = 0;
      end
      if (rd_acc) begin
         exp_a = arch[rd_addr_a];
         exp_b = arch[rd_addr_b];
         if (pre_sz > 0) star++;
      end
      if (wb_acc) begin
         arch[wb_addr] = wb_data;
         pq.push_back('{a: wb_addr, d: wb_data});
      end
      @(posedge clock);
      #1;
      rsp_v = rd_rsp_valid;
      rsp_a = rd_data_a;
      rsp_b = rd_data_b;
      fdone = flush_done;
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      rd_req_valid = 1'b0;
      wb_valid     = 1'b0;
      flush_req    = 1'b0;
      rd_addr_a    = '0;
      rd_addr_b    = '0;
      wb_addr      = '0;
      wb_data      = '0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int c = 0; c < 20 && pq.size() > 0; c++) tick();
      checks++;
      if (pq.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d want 0", pq.size());
      end
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (rd_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp_valid: got %b want 0", rd_rsp_valid);
      end
      checks++;
      if (rd_data_a !== '0 || rd_data_b !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h want 0/0",
                  rd_data_a, rd_data_b);
      end
      checks++;
      if (flush_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush_done: got %b want 0", flush_done);
      end
      checks++;
      if (rf_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_rf_write: got %b want 0", rf_write);
      end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if (wb_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_wb_ready: got %b want 1", wb_ready);
      end
      @(negedge clock);
   endtask

   task automatic test_writes();
      int nw = 0;
      int seen = 0;
      for (int c = 0; c < 14 && (nw < 4 || pq.size() > 0); c++) begin
         if (nw < 4) begin
            wb_valid = 1'b1;
            wb_addr  = ADDR_W'(nw + 1);
            wb_data  = DATA_W'((nw + 1) * 32'h11);
         end else wb_valid = 1'b0;
         tick();
         checks++;
         if (o_wb_ready !== (pre_sz < 4)) begin
            errors++;
            $display("FAIL wr_wb_ready: got %b want %b",
                     o_wb_ready, pre_sz < 4);
         end
         if (wb_acc) nw++;
         if (o_rf_write) begin
            seen++;
            checks++;
            if (!has_front || o_rf_rt !== exp_rt ||
                o_rf_wd !== exp_wd || int'(o_rf_rt) != seen) begin
               errors++;
               $display("FAIL wr_order: got r%0d=%h want r%0d=%h",
                        o_rf_rt, o_rf_wd, seen, exp_wd);
            end
         end
      end
      wb_valid = 1'b0;
      checks++;
      if (seen != 4) begin
         errors++;
         $display("FAIL wr_count: got %0d want 4", seen);
      end
   endtask

   task automatic test_read_basic();
      rd_req_valid = 1'b1;
      rd_addr_a    = 6'd1;
      rd_addr_b    = 6'd2;
      tick();
      rd_req_valid = 1'b0;
      checks++;
      if (o_rd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rd_ready: got %b want 1", o_rd_ready);
      end
      checks++;
      if (rsp_v !== 1'b1 || rsp_a !== 32'h11 || rsp_b !== 32'h22) begin
         errors++;
         $display("FAIL rd_rsp: got v=%b %h/%h want v=1 11/22",
                  rsp_v, rsp_a, rsp_b);
      end
      tick();
      checks++;
      if (rsp_v !== 1'b0) begin
         errors++;
         $display("FAIL rd_rsp_pulse: got %b want 0", rsp_v);
      end
   endtask

   task automatic test_hazard();
      int waited = 0;
      logic acc = 1'b0;
      int want_wait;
`ifdef RF_BYPASS_EN
      want_wait = 0;
`else
      want_wait = 1;
`endif
      wb_valid = 1'b1;
      wb_addr  = 6'd5;
      wb_data  = 32'hAA;
      tick();
      wb_valid     = 1'b0;
      rd_req_valid = 1'b1;
      rd_addr_a    = 6'd5;
      rd_addr_b    = 6'd0;
      for (int c = 0; c < 8 && !acc; c++) begin
         tick();
         if (o_rd_ready) acc = 1'b1;
         else waited++;
      end
      rd_req_valid = 1'b0;
      checks++;
      if (!acc || waited != want_wait) begin
         errors++;
         $display("FAIL hz_stall: got acc=%b wait=%0d want 1/%0d",
                  acc, waited, want_wait);
      end
      checks++;
      if (rsp_v !== 1'b1 || rsp_a !== 32'hAA) begin
         errors++;
         $display("FAIL hz_data: got v=%b %h want v=1 aa",
                  rsp_v, rsp_a);
      end
      drain();
   endtask

   task automatic test_starve();
      int grants = 0;
      logic wr = 1'b0;
      logic rdy_on_wr = 1'b1;
      wb_valid = 1'b1;
      wb_addr  = 6'd6;
      wb_data  = 32'h66;
      tick();
      wb_valid     = 1'b0;
      rd_req_valid = 1'b1;
      rd_addr_a    = 6'd7;
      rd_addr_b    = 6'd8;
      for (int c = 0; c < 10 && !wr; c++) begin
         tick();
         if (o_rf_write) begin
            wr = 1'b1;
            rdy_on_wr = o_rd_ready;
         end else if (o_rd_ready) grants++;
      end
      checks++;
      if (!wr || grants != 3) begin
         errors++;
         $display("FAIL starve: got wr=%b grants=%0d want 1/3",
                  wr, grants);
      end
      checks++;
      if (rdy_on_wr !== 1'b0) begin
         errors++;
         $display("FAIL starve_rd_ready: got %b want 0", rdy_on_wr);
      end
      tick();
      checks++;
      if (o_rd_ready !== 1'b1) begin
         errors++;
         $display("FAIL starve_resume: got %b want 1", o_rd_ready);
      end
      rd_req_valid = 1'b0;
      drain();
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) begin
         rd_req_valid = 1'b1;
         rd_addr_a    = 6'd9;
         rd_addr_b    = 6'd10;
         wb_valid     = 1'b1;
         wb_addr      = ADDR_W'(20 + i);
         wb_data      = $urandom;
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      int writes = 0;
      int first = -1;
      int last = -1;
      int pulses = 0;
      int rd_bad = 0;
      int wb_bad = 0;
      logic acc = 1'b0;
      fill(4);
      checks++;
      if (pq.size() != 4) begin
         errors++;
         $display("FAIL fl_fill: got %0d want 4", pq.size());
      end
      flush_req    = 1'b1;
      rd_req_valid = 1'b1;
      rd_addr_a    = 6'd11;
      wb_valid     = 1'b1;
      wb_addr      = 6'd30;
      wb_data      = 32'h3030;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (o_rd_ready) rd_bad++;
         if (o_wb_ready) wb_bad++;
         if (o_rf_write) begin
            writes++;
            if (first < 0) first = c;
            last = c;
         end
         if (fdone) pulses++;
      end
      checks++;
      if (writes != 4 || last - first != 3) begin
         errors++;
         $display("FAIL fl_writes: got %0d span=%0d want 4/3",
                  writes, last - first);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL fl_done: got %0d pulses want 1", pulses);
      end
      checks++;
      if (rd_bad != 0 || wb_bad != 0) begin
         errors++;
         $display("FAIL fl_refuse: got rd=%0d wb=%0d want 0/0",
                  rd_bad, wb_bad);
      end
      flush_req = 1'b0;
      wb_valid  = 1'b0;
      for (int c = 0; c < 4 && !acc; c++) begin
         tick();
         if (o_rd_ready) acc = 1'b1;
      end
      rd_req_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL fl_resume: got %b want 1", acc);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int writes = 0;
      fill(3);
      reset_n = 1'b0;
      #1;
      checks++;
      if (rf_write !== 1'b0 || rd_rsp_valid !== 1'b0 ||
          rd_data_a !== '0 || flush_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got w=%b v=%b a=%h fd=%b want 0",
                  rf_write, rd_rsp_valid, rd_data_a, flush_done);
      end
      pq.delete();
      foreach (arch[i]) arch[i] = comm[i];
      star = 0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (o_rf_write) writes++;
      end
      checks++;
      if (writes != 0) begin
         errors++;
         $display("FAIL rst_mid_writes: got %0d want 0", writes);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rd_req_valid = $urandom_range(0, 9) < 6;
         rd_addr_a    = ADDR_W'($urandom_range(0, 7));
         rd_addr_b    = ADDR_W'($urandom_range(0, 7));
         wb_valid     = 1'($urandom_range(0, 1));
         wb_addr      = ADDR_W'($urandom_range(0, 7));
         wb_data      = $urandom;
         tick();
         checks++;
         if (o_wb_ready !== (pre_sz < 4)) begin
            errors++;
            $display("FAIL rnd_wb_ready: got %b want %b",
                     o_wb_ready, pre_sz < 4);
         end
         if (pre_sz == 4 || (!rd_req_valid && pre_sz > 0)) begin
            checks++;
            if (o_rf_write !== 1'b1) begin
               errors++;
               $display("FAIL rnd_must_write: got %b want 1",
                        o_rf_write);
            end
         end
         if (o_rf_write) begin
            checks++;
            if (!has_front || o_rf_rt !== exp_rt ||
                o_rf_wd !== exp_wd) begin
               errors++;
               $display("FAIL rnd_wr: got r%0d=%h want r%0d=%h",
                        o_rf_rt, o_rf_wd, exp_rt, exp_wd);
            end
         end
         if (rd_req_valid && pre_sz == 0) begin
            checks++;
            if (o_rd_ready !== 1'b1) begin
               errors++;
               $display("FAIL rnd_rd_ready: got %b want 1", o_rd_ready);
            end
         end
         checks++;
         if (star > 3) begin
            errors++;
            $display("FAIL rnd_starve: got %0d want <=3", star);
         end
`ifndef RF_BYPASS_EN
         checks++;
         if (rd_acc && hz) begin
            errors++;
            $display("FAIL rnd_hazard: got accept want refuse");
         end
`endif
         checks++;
         if (rsp_v !== rd_acc ||
             (rd_acc && (rsp_a !== exp_a || rsp_b !== exp_b))) begin
            errors++;
            $display("FAIL rnd_rsp: got v=%b %h/%h want v=%b %h/%h",
                     rsp_v, rsp_a, rsp_b, rd_acc, exp_a, exp_b);
         end
      end
      drain();
   endtask

   task automatic test_final_rf();
      int bad = 0;
      foreach (comm[i]) if (rfm[i] !== comm[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL final_rf: got %0d wrong regs want 0", bad);
      end
   endtask

   initial begin
      foreach (rfm[i]) begin
         rfm[i]  = '0;
         arch[i] = '0;
         comm[i] = '0;
      end
      rf_rsout = '0;
      rf_rtout = '0;
      test_reset();
      test_writes();
      drain();
      test_read_basic();
      test_hazard();
      test_starve();
      test_flush();
      test_reset_mid();
      test_random();
      test_final_rf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
